// File: rtl/vdp_sprite_meta_dma.sv
// Sprite metadata DMA: streams source words into the x/y/g sprite metadata
// blocks selected by block_mask, with at most two reads in flight. Reads are
// only issued during vblank; returned words are always written.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing source reads (vblank-gated), writing returned words
// DRAIN | all reads issued, waiting for outstanding returns
// DONE  | one-cycle completion pulse, busy already low
module vdp_sprite_meta_dma #(
  parameter int SRC_ADDRESS_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [SRC_ADDRESS_WIDTH-1:0] src_address,
  input  logic [7:0]                   dest_index,
  input  logic [7:0]                   length_m1,
  input  logic [2:0]                   block_mask,
  input  logic                         vblank,
  output logic                         busy,
  output logic                         done,
  output logic [SRC_ADDRESS_WIDTH-1:0] src_read_address,
  output logic                         src_read_req,
  input  logic                         src_read_ready,
  input  logic [15:0]                  src_read_data,
  input  logic                         src_read_data_valid,
  output logic [7:0]                   meta_address,
  output logic [15:0]                  meta_write_data,
  output logic [2:0]                   meta_block_select,
  output logic                         meta_we
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  dest_base;
  logic [7:0]  len_m1;
  logic [2:0]  mask;
  logic [1:0]  issue_blk, ret_blk;
  logic [7:0]  issue_cnt, ret_cnt;
  logic [1:0]  outstanding;
  logic        accept, ret, last_req;
  logic [2:0]  issue_nxt, ret_nxt;

  // Lowest selected block; only meaningful when the mask is non-zero.
  function automatic logic [1:0] first_blk(input logic [2:0] m);
    if (m[0])      first_blk = 2'd0;
    else if (m[1]) first_blk = 2'd1;
    else           first_blk = 2'd2;
  endfunction

  // Next selected block after cur, returned as {found, index}.
  function automatic logic [2:0] next_blk(input logic [2:0] m, input logic [1:0] cur);
    next_blk = 3'b000;
    case (cur)
      2'd0: begin
        if (m[1])      next_blk = {1'b1, 2'd1};
        else if (m[2]) next_blk = {1'b1, 2'd2};
      end
      2'd1: begin
        if (m[2])      next_blk = {1'b1, 2'd2};
      end
      default: next_blk = 3'b000;
    endcase
  endfunction

  // Handshake decode, next-state logic and status outputs.
  always_comb begin
    state_nxt    = state;
    src_read_req = (state == ISSUE) && vblank && (outstanding < 2'd2);
    accept       = src_read_req && src_read_ready;
    // Returns outside an active transfer (idle, or after a reset) are dropped.
    ret          = src_read_data_valid && ((state == ISSUE) || (state == DRAIN))
                   && (outstanding != 2'd0);
    issue_nxt    = next_blk(mask, issue_blk);
    ret_nxt      = next_blk(mask, ret_blk);
    last_req     = (issue_cnt == len_m1) && !issue_nxt[2];
    busy         = (state == ISSUE) || (state == DRAIN);
    done         = (state == DONE);
    case (state)
      IDLE: begin
        if (start) state_nxt = (block_mask == 3'b000) ? DONE : ISSUE;
      end
      ISSUE: begin
        if (accept && last_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        // The final return's write is registered in the same edge that
        // clears the count, so zero here means every write has been issued.
        if (outstanding == 2'd0) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Transfer parameters, issue/return position tracking and outstanding count.
  always_ff @(posedge clk) begin
    if (reset) begin
      dest_base        <= 8'd0;
      len_m1           <= 8'd0;
      mask             <= 3'b000;
      issue_blk        <= 2'd0;
      ret_blk          <= 2'd0;
      issue_cnt        <= 8'd0;
      ret_cnt          <= 8'd0;
      outstanding      <= 2'd0;
      src_read_address <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        dest_base        <= dest_index;
        len_m1           <= length_m1;
        mask             <= block_mask;
        issue_blk        <= first_blk(block_mask);
        ret_blk          <= first_blk(block_mask);
        issue_cnt        <= 8'd0;
        ret_cnt          <= 8'd0;
        outstanding      <= 2'd0;
        src_read_address <= src_address;
      end
    end else begin
      if (accept) begin
        src_read_address <= src_read_address + SRC_ADDRESS_WIDTH'(1);
        if (issue_cnt == len_m1) begin
          issue_cnt <= 8'd0;
          issue_blk <= issue_nxt[1:0];
        end else begin
          issue_cnt <= issue_cnt + 8'd1;
        end
      end
      if (ret) begin
        if (ret_cnt == len_m1) begin
          ret_cnt <= 8'd0;
          ret_blk <= ret_nxt[1:0];
        end else begin
          ret_cnt <= ret_cnt + 8'd1;
        end
      end
      case ({accept, ret})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Registered metadata write, one cycle after each accepted return.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_we           <= 1'b0;
      meta_address      <= 8'd0;
      meta_write_data   <= 16'd0;
      meta_block_select <= 3'b000;
    end else begin
      meta_we <= ret;
      if (ret) begin
        meta_address      <= dest_base + ret_cnt;
        meta_write_data   <= src_read_data;
        meta_block_select <= 3'b001 << ret_blk;
      end
    end
  end

endmodule
